instruction_fetch_unit: RTL and testbench

//   Producer side of the opcode interface: fetches 32-bit instructions from instruction

---
 rtl/instruction_fetch_unit.sv | 68 ++++++
 tb/tb_instruction_fetch_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches instructions over req/ready, holds each for execute; ports: clk, reset, imem_req/addr/ready/rdata, inst_valid/inst/part_of_inst/inst_pc, inst_accept, redirect/redirect_pc, halt_req, is_halted, fault, retired_cnt
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter bit          CHECK_OPC = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [6:0]  part_of_inst,
   output logic [31:0] inst_pc,
   input  logic        inst_accept,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        is_halted,
   output logic        fault,
   output logic [31:0] retired_cnt
);
   typedef enum logic [1:0] {FETCH, HOLD, ILL, HALTED} state_t;
   state_t state, state_nx;
   logic [31:0] pc, pc_nx;
   logic legal, take, acc, bad_target;
   always_comb begin
      legal = !CHECK_OPC || (imem_rdata[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011,
              7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011, 7'b0110111, 7'b0010111});
      take = state == FETCH && imem_ready;
      acc = state == HOLD && inst_accept;
      bad_target = redirect && redirect_pc[1:0] != 2'b00;
      state_nx = state;
      pc_nx = pc;
      if (take) state_nx = legal ? HOLD : ILL;
      if (state == ILL) state_nx = HALTED;
      if (acc) begin
         state_nx = (halt_req || bad_target) ? HALTED : FETCH;
         pc_nx = redirect ? redirect_pc : pc + 32'd4;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         pc <= RESET_PC;
         inst <= '0;
         inst_pc <= '0;
         retired_cnt <= '0;
         fault <= 1'b0;
      end else begin
         state <= state_nx;
         pc <= pc_nx;
         if (take) begin
            inst <= imem_rdata;
            inst_pc <= pc;
         end
         if (acc) retired_cnt <= retired_cnt + 32'd1;
         // halt_req outranks a misaligned redirect, so it suppresses the fault
         if (state == ILL || (acc && !halt_req && bad_target)) fault <= 1'b1;
      end
   end
   assign imem_req = state == FETCH;
   assign imem_addr = pc;
   assign inst_valid = state == HOLD;
   assign part_of_inst = inst[6:0];
   assign is_halted = state == HALTED;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of the fetch unit, including a CHECK_OPC=0 instance
module tb_instruction_fetch_unit;
   logic clk = 1'b0, reset = 1'b1;
   logic imem_ready = 1'b0, inst_accept = 1'b0, redirect = 1'b0, halt_req = 1'b0;
   logic [31:0] imem_rdata = 32'h0, redirect_pc = 32'h0;
   logic imem_req, inst_valid, is_halted, fault;
   logic [31:0] imem_addr, inst, inst_pc, retired_cnt;
   logic [6:0] part_of_inst;
   logic z_imem_req, z_inst_valid, z_is_halted, z_fault;
   logic [31:0] z_imem_addr, z_inst, z_inst_pc, z_retired_cnt;
   logic [6:0] z_part_of_inst;
   int tests = 0, failed = 0;

   always #5 clk = ~clk;

   instruction_fetch_unit dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
      .inst(inst), .part_of_inst(part_of_inst), .inst_pc(inst_pc),
      .inst_accept(inst_accept), .redirect(redirect), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .is_halted(is_halted), .fault(fault), .retired_cnt(retired_cnt));

   instruction_fetch_unit #(.CHECK_OPC(1'b0)) dut0 (
      .clk(clk), .reset(reset), .imem_req(z_imem_req), .imem_addr(z_imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst_valid(z_inst_valid),
      .inst(z_inst), .part_of_inst(z_part_of_inst), .inst_pc(z_inst_pc),
      .inst_accept(inst_accept), .redirect(redirect), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .is_halted(z_is_halted), .fault(z_fault), .retired_cnt(z_retired_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic restart();
      @(negedge clk);
      reset = 1'b1;
      imem_ready = 1'b0; inst_accept = 1'b0; redirect = 1'b0; halt_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_req", 32'(imem_req), 1);
      chk("rst_valid", 32'(inst_valid), 0);
      chk("rst_halt", 32'(is_halted), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_cnt", retired_cnt, 0);
      chk("rst_part", 32'(part_of_inst), 0);
      // 1: back-to-back nops
      @(negedge clk);
      reset = 1'b0; imem_ready = 1'b1; inst_accept = 1'b1; imem_rdata = 32'h0000_0013;
      for (int i = 0; i < 3; i++) begin
         chk("t1_req", 32'(imem_req), 1);
         chk("t1_addr", imem_addr, 32'(4 * i));
         chk("t1_nvalid", 32'(inst_valid), 0);
         @(negedge clk);
         chk("t1_valid", 32'(inst_valid), 1);
         chk("t1_ipc", inst_pc, 32'(4 * i));
         chk("t1_part", 32'(part_of_inst), 32'h13);
         @(negedge clk);
      end
      chk("t1_addr12", imem_addr, 32'd12);
      chk("t1_cnt", retired_cnt, 32'd3);
      // 2: slow ready
      restart();
      inst_accept = 1'b0; imem_rdata = 32'h0050_0093;
      for (int i = 0; i < 4; i++) begin
         chk("t2_req", 32'(imem_req), 1);
         chk("t2_addr", imem_addr, 0);
         chk("t2_nvalid", 32'(inst_valid), 0);
         if (i == 3) imem_ready = 1'b1;
         @(negedge clk);
      end
      imem_ready = 1'b0;
      chk("t2_valid", 32'(inst_valid), 1);
      chk("t2_req0", 32'(imem_req), 0);
      // 3: stall in HOLD then redirect
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         chk("t3_inst", inst, 32'h0050_0093);
         chk("t3_ipc", inst_pc, 0);
         chk("t3_part", 32'(part_of_inst), 32'h13);
         chk("t3_valid", 32'(inst_valid), 1);
         @(negedge clk);
      end
      inst_accept = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
      @(negedge clk);
      inst_accept = 1'b0; redirect = 1'b0;
      chk("t3_req", 32'(imem_req), 1);
      chk("t3_addr", imem_addr, 32'h40);
      chk("t3_cnt", retired_cnt, 1);
      imem_ready = 1'b1; imem_rdata = 32'h0000_006F;
      @(negedge clk);
      imem_ready = 1'b0;
      chk("t3_ipc40", inst_pc, 32'h40);
      chk("t3_part6f", 32'(part_of_inst), 32'h6F);
      // 4: misaligned redirect
      inst_accept = 1'b1; redirect = 1'b1; redirect_pc = 32'h42;
      @(negedge clk);
      inst_accept = 1'b0; redirect = 1'b0; imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("t4_halt", 32'(is_halted), 1);
         chk("t4_fault", 32'(fault), 1);
         chk("t4_req", 32'(imem_req), 0);
         chk("t4_valid", 32'(inst_valid), 0);
         @(negedge clk);
      end
      chk("t4_cnt", retired_cnt, 2);
      restart();
      imem_ready = 1'b1; imem_rdata = 32'h0000_0073;
      @(negedge clk);
      imem_ready = 1'b0;
      chk("t4_hvalid", 32'(inst_valid), 1);
      inst_accept = 1'b1; halt_req = 1'b1; redirect = 1'b1; redirect_pc = 32'h42;
      @(negedge clk);
      inst_accept = 1'b0; halt_req = 1'b0; redirect = 1'b0;
      chk("t4_hhalt", 32'(is_halted), 1);
      chk("t4_hfault", 32'(fault), 0);
      chk("t4_hcnt", retired_cnt, 1);
      // 5: illegal opcode
      restart();
      imem_ready = 1'b1; imem_rdata = 32'h0000_007F;
      @(negedge clk);
      imem_ready = 1'b0; inst_accept = 1'b1;
      chk("t5_valid", 32'(inst_valid), 0);
      chk("t5_req", 32'(imem_req), 0);
      chk("t5_part", 32'(part_of_inst), 32'h7F);
      chk("t5_fault0", 32'(fault), 0);
      chk("t5_halt0", 32'(is_halted), 0);
      chk("t5z_valid", 32'(z_inst_valid), 1);
      chk("t5z_req", 32'(z_imem_req), 0);
      chk("t5z_addr", z_imem_addr, 0);
      chk("t5z_inst", z_inst, 32'h7F);
      chk("t5z_part", 32'(z_part_of_inst), 32'h7F);
      chk("t5z_ipc", z_inst_pc, 0);
      @(negedge clk);
      inst_accept = 1'b0;
      chk("t5_fault", 32'(fault), 1);
      chk("t5_halt", 32'(is_halted), 1);
      chk("t5_cnt", retired_cnt, 0);
      chk("t5z_cnt", z_retired_cnt, 1);
      chk("t5z_fault", 32'(z_fault), 0);
      chk("t5z_halt", 32'(z_is_halted), 0);
      // 6: async reset mid-FETCH and mid-HOLD, counter wrap
      restart();
      imem_ready = 1'b1; inst_accept = 1'b1; imem_rdata = 32'h0000_0037;
      @(negedge clk);
      imem_ready = 1'b0;
      @(negedge clk);
      inst_accept = 1'b0;
      chk("t6_addr4", imem_addr, 4);
      #2 reset = 1'b1;
      #1;
      chk("t6_faddr", imem_addr, 0);
      chk("t6_fcnt", retired_cnt, 0);
      chk("t6_finst", inst, 0);
      @(negedge clk);
      reset = 1'b0; imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      chk("t6_hvalid1", 32'(inst_valid), 1);
      #2 reset = 1'b1;
      #1;
      chk("t6_hvalid", 32'(inst_valid), 0);
      chk("t6_hreq", 32'(imem_req), 1);
      chk("t6_hinst", inst, 0);
      chk("t6_hpart", 32'(part_of_inst), 0);
      @(negedge clk);
      reset = 1'b0;
      chk("t6_raddr", imem_addr, 0);
      chk("t6_rreq", 32'(imem_req), 1);
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      force dut.retired_cnt = 32'hFFFF_FFFF;
      #1 release dut.retired_cnt;
      chk("t6_cntmax", retired_cnt, 32'hFFFF_FFFF);
      inst_accept = 1'b1;
      @(negedge clk);
      inst_accept = 1'b0;
      chk("t6_wrap", retired_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
